// File: rtl/irq_controller_pkg.sv
// irq_controller_pkg
// Shared definitions for the prioritised interrupt controller: register
// window offsets, the reset value of the mask register, the interrupt code
// type and a one-hot helper used when setting/clearing a single line.
package irq_controller_pkg;

    // Register offsets inside the 8-word window.
    localparam logic [2:0] OFS_PEND   = 3'd0;
    localparam logic [2:0] OFS_MASK   = 3'd1;
    localparam logic [2:0] OFS_ISR    = 3'd2;
    localparam logic [2:0] OFS_ACK    = 3'd3;
    localparam logic [2:0] OFS_EOI    = 3'd4;
    localparam logic [2:0] OFS_STATUS = 3'd5;

    // All lines come out of reset masked.
    localparam logic [15:0] MASK_RESET = 16'hFFFF;

    typedef logic [3:0] irqCode_t;

    // One-hot vector selecting interrupt line `code`.
    function automatic logic [15:0] bitMask(input irqCode_t code);
        return 16'h0001 << code;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc
// Finds the lowest set bit (highest priority) of a 16-bit vector.
// Ports:
//   vec   - input vector, bit 0 has the highest priority
//   idx   - index of the lowest set bit (0 when vec is zero)
//   valid - 1 when any bit of vec is set
module irq_prio_enc
    import irq_controller_pkg::*;
(
    input  logic [15:0] vec,
    output irqCode_t    idx,
    output logic        valid
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        idx   = 4'd0;
        valid = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = 4'(i);
                valid = 1'b1;
            end else begin
                idx   = idx;
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// irq_controller
// Prioritised 16-line interrupt controller with a memory-mapped register
// window on the CPU's shared address/write/data bus.
// Ports:
//   CLK - system clock, rising edge
//   RST - synchronous active-low reset
//   IN  - asynchronous interrupt lines, bit 0 highest priority
//   A   - CPU address bus
//   W   - CPU write strobe, active-high
//   D   - CPU data bus, driven only during register reads
//   IRQ - registered interrupt request to the CPU
//   IC  - registered code of the requesting line (valid while IRQ=1)
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'hFF00,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] IN,
    input  logic [15:0] A,
    input  logic        W,
    inout  wire  [15:0] D,
    output logic        IRQ,
    output logic [3:0]  IC
);

    logic [15:0] syncR [SYNC_STAGES];
    logic [15:0] histR;
    logic [15:0] pendR;
    logic [15:0] maskR;
    logic [15:0] isrR;
    logic        irqR;
    irqCode_t    icR;
    logic        wPrevR;

    logic        hit_s;
    logic [2:0]  ofs_s;
    logic        wrEn_s;
    logic        ackEn_s;
    logic        eoiEn_s;
    logic        maskEn_s;
    logic [15:0] rise_s;
    logic [15:0] cand_s;
    irqCode_t    candIdx_s;
    logic        candValid_s;
    irqCode_t    isrIdx_s;
    logic        isrValid_s;
    logic [4:0]  svcLevel_s;
    logic        arbIrq_s;
    logic [15:0] pendNext_s;
    logic [15:0] isrNext_s;
    logic [15:0] maskNext_s;
    logic        irqNext_s;
    irqCode_t    icNext_s;
    logic        rdEn_s;
    logic [15:0] rdData_s;

    assign hit_s  = (A[15:3] == BASE[15:3]);
    assign ofs_s  = A[2:0];
    // Only the first cycle of a held write strobe performs a write.
    assign wrEn_s   = W & hit_s & ~wPrevR;
    assign ackEn_s  = wrEn_s & (ofs_s == OFS_ACK) & irqR;
    assign eoiEn_s  = wrEn_s & (ofs_s == OFS_EOI);
    assign maskEn_s = wrEn_s & (ofs_s == OFS_MASK);

    assign rise_s = syncR[SYNC_STAGES-1] & ~histR;
    assign cand_s = pendR & ~maskR;

    irq_prio_enc u_candEnc (
        .vec   (cand_s),
        .idx   (candIdx_s),
        .valid (candValid_s)
    );

    irq_prio_enc u_isrEnc (
        .vec   (isrR),
        .idx   (isrIdx_s),
        .valid (isrValid_s)
    );

    // An empty ISR is treated as level 16 so that any candidate outranks it.
    assign svcLevel_s = isrValid_s ? {1'b0, isrIdx_s} : 5'd16;
    assign arbIrq_s   = candValid_s & ({1'b0, candIdx_s} < svcLevel_s);

    // Next-state of PEND/ISR/MASK/IRQ/IC; a new edge always wins over an ACK clear.
    always_comb begin
        pendNext_s = pendR | rise_s;
        isrNext_s  = isrR;
        maskNext_s = maskR;
        irqNext_s  = 1'b0;
        icNext_s   = icR;
        if (ackEn_s) begin
            pendNext_s = (pendR & ~bitMask(icR)) | rise_s;
            isrNext_s  = isrR | bitMask(icR);
            irqNext_s  = 1'b0;
            icNext_s   = icR;
        end else begin
            irqNext_s = arbIrq_s;
            icNext_s  = arbIrq_s ? candIdx_s : icR;
            if (eoiEn_s) begin
                isrNext_s = isrR & ~bitMask(irqCode_t'(D[3:0]));
            end else begin
                isrNext_s = isrR;
            end
        end
        if (maskEn_s) begin
            maskNext_s = D;
        end else begin
            maskNext_s = maskR;
        end
    end

    // Register read multiplexer.
    always_comb begin
        rdData_s = 16'h0000;
        case (ofs_s)
            OFS_PEND:   rdData_s = pendR;
            OFS_MASK:   rdData_s = maskR;
            OFS_ISR:    rdData_s = isrR;
            OFS_STATUS: rdData_s = {11'b000_0000_0000, irqR, icR};
            default:    rdData_s = 16'h0000;
        endcase
    end

    assign rdEn_s = RST & hit_s & ~W;
    assign D      = rdEn_s ? rdData_s : {16{1'bz}};

    // State registers: synchronisers, edge history, controller state.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                syncR[i] <= 16'h0000;
            end
            histR  <= 16'h0000;
            pendR  <= 16'h0000;
            maskR  <= MASK_RESET;
            isrR   <= 16'h0000;
            irqR   <= 1'b0;
            icR    <= 4'd0;
            wPrevR <= 1'b0;
        end else begin
            syncR[0] <= IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                syncR[i] <= syncR[i-1];
            end
            histR  <= syncR[SYNC_STAGES-1];
            pendR  <= pendNext_s;
            maskR  <= maskNext_s;
            isrR   <= isrNext_s;
            irqR   <= irqNext_s;
            icR    <= icNext_s;
            wPrevR <= W;
        end
    end

    assign IRQ = irqR;
    assign IC  = icR;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
// Self-checking bench for irq_controller: directed scenarios followed by
// randomized bus traffic and interrupt activity, compared cycle by cycle
// against a behavioural model of the controller's rules.
module tb_irq_controller;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] IN  = 16'h0000;
    logic [15:0] A   = 16'h0000;
    logic        W   = 1'b0;
    wire  [15:0] D;
    logic        IRQ;
    logic [3:0]  IC;

    logic        tbDrv  = 1'b0;
    logic [15:0] tbData = 16'h0000;

    assign D = tbDrv ? tbData : {16{1'bz}};

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    logic [15:0] mPend, mMask, mIsr;
    logic        mIrq, mPrevW;
    logic [3:0]  mIc;
    logic [15:0] mPast [3];   // IN sampled 1, 2, 3 edges ago

    irq_controller #(.BASE(BASE), .SYNC_STAGES(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .IN  (IN),
        .A   (A),
        .W   (W),
        .D   (D),
        .IRQ (IRQ),
        .IC  (IC)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lowestSet(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return i;
        end
        return 16;
    endfunction

    function automatic logic [15:0] modelRead(input logic [2:0] off);
        case (off)
            3'd0:    return mPend;
            3'd1:    return mMask;
            3'd2:    return mIsr;
            3'd5:    return {11'b0, mIrq, mIc};
            default: return 16'h0000;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic modelStep();
        logic [15:0] detected, nPend, nIsr, nMask;
        logic        we, nIrq;
        logic [3:0]  nIc;
        logic [2:0]  off;
        int          p, s;
        if (!RST) begin
            mPend = 16'h0000; mMask = 16'hFFFF; mIsr = 16'h0000;
            mIrq = 1'b0; mIc = 4'd0; mPrevW = 1'b0;
            for (int i = 0; i < 3; i++) mPast[i] = 16'h0000;
        end else begin
            // two synchroniser stages then history: edge seen 2 edges after IN rose
            detected = mPast[1] & ~mPast[2];
            we  = W && (A[15:3] == BASE[15:3]) && !mPrevW;
            off = A[2:0];
            p = lowestSet(mPend & ~mMask);
            s = lowestSet(mIsr);
            nPend = mPend | detected;
            nIsr  = mIsr;
            nMask = mMask;
            if (we && off == 3'd3 && mIrq) begin
                nPend = (mPend & ~(16'h0001 << mIc)) | detected;
                nIsr  = mIsr | (16'h0001 << mIc);
                nIrq  = 1'b0;
                nIc   = mIc;
            end else begin
                nIrq = (p < 16) && (p < s);
                nIc  = nIrq ? 4'(p) : mIc;
            end
            if (we && off == 3'd1) nMask = tbData;
            if (we && off == 3'd4) nIsr = mIsr & ~(16'h0001 << tbData[3:0]);
            mPast[2] = mPast[1];
            mPast[1] = mPast[0];
            mPast[0] = IN;
            mPrevW = W;
            mPend = nPend; mIsr = nIsr; mMask = nMask; mIrq = nIrq; mIc = nIc;
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge CLK);
        #1;
        checkVal("irq", {31'b0, IRQ}, {31'b0, mIrq});
        checkVal("ic", {28'b0, IC}, {28'b0, mIc});
    endtask

    task automatic readChk(input string tag, input logic [2:0] off, input logic [15:0] exp);
        A = BASE | {13'b0, off};
        W = 1'b0;
        tbDrv = 1'b0;
        #1;
        checkVal(tag, {16'b0, D}, {16'b0, exp});
    endtask

    task automatic hizChk(input string tag, input logic [15:0] addr);
        A = addr;
        W = 1'b0;
        tbDrv = 1'b1;
        tbData = 16'h5A5A;
        #1;
        checkVal(tag, {16'b0, D}, 32'h0000_5A5A);
        tbDrv = 1'b0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [15:0] data);
        A = BASE | {13'b0, off};
        W = 1'b1;
        tbDrv = 1'b1;
        tbData = data;
        tick();
        W = 1'b0;
        tbDrv = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic [15:0] lines);
        IN = lines;
        tick();
        IN = 16'h0000;
        tick();
        tick();
        tick();
    endtask

    initial begin
        logic [15:0] rv;
        int          op, n;

        // Reset state
        RST = 1'b0;
        tick();
        tick();
        hizChk("hiz_in_reset", BASE | 16'h0001);
        RST = 1'b1;
        readChk("rst_mask", 3'd1, 16'hFFFF);
        readChk("rst_pend", 3'd0, 16'h0000);
        readChk("rst_isr", 3'd2, 16'h0000);
        checkVal("rst_irq", {31'b0, IRQ}, 32'd0);
        hizChk("hiz_outside", 16'h1234);

        // Single request, latency and STATUS
        wr(3'd1, 16'hFFF7);
        IN = 16'h0008;
        tick();
        IN = 16'h0000;
        tick();
        tick();
        checkVal("irq_not_yet", {31'b0, IRQ}, 32'd0);
        tick();
        checkVal("irq_lat", {31'b0, IRQ}, 32'd1);
        checkVal("ic_lat", {28'b0, IC}, 32'd3);
        readChk("status", 3'd5, 16'h0013);

        // ACK moves line 3 into service
        wr(3'd3, 16'h0000);
        readChk("ack_pend", 3'd0, 16'h0000);
        readChk("ack_isr", 3'd2, 16'h0008);
        checkVal("ack_irq", {31'b0, IRQ}, 32'd0);

        // Lower-priority line waits behind line 3
        wr(3'd1, 16'hFFD5);
        pulse(16'h0020);
        tick();
        checkVal("low_waits", {31'b0, IRQ}, 32'd0);
        readChk("low_pend", 3'd0, 16'h0020);

        // EOI releases line 5
        wr(3'd4, 16'h0003);
        readChk("eoi_isr", 3'd2, 16'h0000);
        checkVal("eoi_irq", {31'b0, IRQ}, 32'd1);
        checkVal("eoi_ic", {28'b0, IC}, 32'd5);
        wr(3'd4, 16'h0009);
        checkVal("eoi9_irq", {31'b0, IRQ}, 32'd1);
        checkVal("eoi9_ic", {28'b0, IC}, 32'd5);
        readChk("eoi9_pend", 3'd0, 16'h0020);

        // Higher priority line preempts the waiting one
        pulse(16'h0002);
        checkVal("hi_irq", {31'b0, IRQ}, 32'd1);
        checkVal("hi_ic", {28'b0, IC}, 32'd1);

        // Drain everything
        wr(3'd3, 16'h0000);
        wr(3'd4, 16'h0001);
        wr(3'd3, 16'h0000);
        wr(3'd4, 16'h0005);
        readChk("drain_pend", 3'd0, 16'h0000);
        readChk("drain_isr", 3'd2, 16'h0000);

        // Held W on ACK acknowledges only once
        wr(3'd1, 16'hFFC5);
        pulse(16'h0018);
        checkVal("two_ic", {28'b0, IC}, 32'd3);
        A = BASE | 16'h0003;
        W = 1'b1;
        tbDrv = 1'b1;
        tbData = 16'h0000;
        tick();
        tick();
        tick();
        W = 1'b0;
        tbDrv = 1'b0;
        tick();
        readChk("held_pend", 3'd0, 16'h0010);
        readChk("held_isr", 3'd2, 16'h0008);
        checkVal("held_irq", {31'b0, IRQ}, 32'd0);

        // Held W on MASK takes only the first data value
        A = BASE | 16'h0001;
        W = 1'b1;
        tbDrv = 1'b1;
        tbData = 16'hFFE5;
        tick();
        tbData = 16'h0000;
        tick();
        tick();
        W = 1'b0;
        tbDrv = 1'b0;
        tick();
        readChk("held_mask", 3'd1, 16'hFFE5);
        wr(3'd1, 16'hFFC5);

        // Reset while a request is active and a line is in service
        pulse(16'h0002);
        checkVal("pre_rst_irq", {31'b0, IRQ}, 32'd1);
        checkVal("pre_rst_ic", {28'b0, IC}, 32'd1);
        RST = 1'b0;
        tick();
        checkVal("post_rst_irq", {31'b0, IRQ}, 32'd0);
        RST = 1'b1;
        readChk("post_rst_pend", 3'd0, 16'h0000);
        readChk("post_rst_isr", 3'd2, 16'h0000);
        readChk("post_rst_mask", 3'd1, 16'hFFFF);

        // Randomized traffic against the model
        for (int it = 0; it < 900; it++) begin
            rv = 16'($urandom);
            IN = ($urandom_range(0, 2) == 0) ? (rv & 16'($urandom) & 16'($urandom)) : 16'h0000;
            op = $urandom_range(0, 11);
            case (op)
                0: wr(3'd1, 16'($urandom) | 16'($urandom));
                1, 2: wr(3'd3, 16'($urandom));
                3: begin
                    if (mIsr != 16'h0000 && $urandom_range(0, 3) != 0)
                        wr(3'd4, 16'(lowestSet(mIsr)) | (16'($urandom) & 16'hFFF0));
                    else
                        wr(3'd4, 16'($urandom));
                end
                4: begin
                    n = $urandom_range(0, 7);
                    readChk("rnd_read", 3'(n), modelRead(3'(n)));
                    tick();
                end
                5: wr(3'($urandom_range(6, 7)), 16'($urandom));
                6: begin
                    A = 16'($urandom);
                    if (A[15:3] == BASE[15:3]) A = 16'h0000;
                    W = 1'b1;
                    tbDrv = 1'b1;
                    tbData = 16'($urandom);
                    tick();
                    W = 1'b0;
                    tbDrv = 1'b0;
                    tick();
                end
                7: begin
                    A = BASE | 16'($urandom_range(0, 7));
                    W = 1'b1;
                    tbDrv = 1'b1;
                    n = $urandom_range(2, 4);
                    for (int k = 0; k < n; k++) begin
                        tbData = 16'($urandom);
                        tick();
                    end
                    W = 1'b0;
                    tbDrv = 1'b0;
                    tick();
                end
                8: begin
                    if ($urandom_range(0, 40) == 0) begin
                        RST = 1'b0;
                        tick();
                        RST = 1'b1;
                    end else begin
                        tick();
                    end
                end
                default: tick();
            endcase
        end
        readChk("final_pend", 3'd0, mPend);
        readChk("final_isr", 3'd2, mIsr);
        readChk("final_mask", 3'd1, mMask);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
